// File: rtl/itof_pipe_if.sv
// Valid/ready bundle between the operand mux, the integer-to-float converter
// and its result consumer.
interface itof_pipe_if #(
  parameter int IW = 32,
  parameter int TW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [IW-1:0] x;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   y;
  logic          inexact;
  logic [TW-1:0] out_tag;

  modport master (
    output in_valid, in_signed, x, in_tag, out_ready,
    input  in_ready, out_valid, y, inexact, out_tag
  );

  modport slave (
    input  in_valid, in_signed, x, in_tag, out_ready,
    output in_ready, out_valid, y, inexact, out_tag
  );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage integer-to-binary32 converter (sign/abs, normalise, round/pack)
// with round-to-nearest-even, inexact flag and a tag carried alongside.
module itof_pipe #(
  parameter int IW = 32,
  parameter int TW = 4
) (
  input  logic      clk,
  input  logic      rstn,
  itof_pipe_if.slave io
);
  localparam int KW = $clog2(IW);
  localparam int EW = IW + 25;

  function automatic logic [KW-1:0] lead_one(input logic [IW-1:0] a);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < IW; i++) begin
      if (a[i]) k = KW'(i);
    end
    return k;
  endfunction

  logic          en_s;
  logic          v1_q, v2_q, v3_q;
  logic          s1_q, s2_q;
  logic [IW-1:0] a1_q, n2_q;
  logic [KW-1:0] k2_q;
  logic          z2_q;
  logic [TW-1:0] tag1_q, tag2_q, tag3_q;
  logic [31:0]   y_q;
  logic          inexact_q;

  logic          s1_d;
  logic [IW-1:0] a1_d, n2_d;
  logic [KW-1:0] k2_d;
  logic          z2_d;
  logic [EW-1:0] ext_s;
  logic [22:0]   mant_s;
  logic          guard_s, sticky_s, rnd_s;
  logic [23:0]   sum_s;
  logic [7:0]    exp_s;
  logic [31:0]   y_d;
  logic          inexact_d;

  // A stalled output freezes the whole pipe, bubbles included.
  assign en_s         = ~v3_q | io.out_ready;
  assign io.in_ready  = en_s;
  assign io.out_valid = v3_q;
  assign io.y         = y_q;
  assign io.inexact   = inexact_q;
  assign io.out_tag   = tag3_q;

  // Per-stage datapath: magnitude, leading-one normalise, then round and pack.
  always_comb begin
    s1_d      = io.in_signed & io.x[IW-1];
    a1_d      = s1_d ? (~io.x + IW'(1)) : io.x;
    k2_d      = lead_one(a1_q);
    z2_d      = (a1_q == '0);
    n2_d      = a1_q << (KW'(IW - 1) - k2_d);
    // Pad below so guard/sticky read as zero when fewer than 25 bits exist.
    ext_s     = {n2_q, 25'd0};
    mant_s    = ext_s[EW-2 -: 23];
    guard_s   = ext_s[EW-25];
    sticky_s  = |ext_s[EW-26:0];
    rnd_s     = guard_s & (sticky_s | mant_s[0]);
    sum_s     = {1'b0, mant_s} + {23'd0, rnd_s};
    exp_s     = 8'd127 + 8'(k2_q) + {7'd0, sum_s[23]};
    y_d       = z2_q ? 32'h0000_0000 : {s2_q, exp_s, sum_s[22:0]};
    inexact_d = ~z2_q & (guard_s | sticky_s);
  end

  // Stage 1: operand sign and absolute value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q   <= 1'b0;
      s1_q   <= 1'b0;
      a1_q   <= '0;
      tag1_q <= '0;
    end else if (en_s) begin
      v1_q   <= io.in_valid;
      s1_q   <= s1_d;
      a1_q   <= a1_d;
      tag1_q <= io.in_tag;
    end
  end

  // Stage 2: normalised magnitude with its leading-one position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q   <= 1'b0;
      s2_q   <= 1'b0;
      n2_q   <= '0;
      k2_q   <= '0;
      z2_q   <= 1'b0;
      tag2_q <= '0;
    end else if (en_s) begin
      v2_q   <= v1_q;
      s2_q   <= s1_q;
      n2_q   <= n2_d;
      k2_q   <= k2_d;
      z2_q   <= z2_d;
      tag2_q <= tag1_q;
    end
  end

  // Stage 3: packed result registers driving the outputs directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3_q      <= 1'b0;
      y_q       <= 32'h0000_0000;
      inexact_q <= 1'b0;
      tag3_q    <= '0;
    end else if (en_s) begin
      v3_q      <= v2_q;
      y_q       <= y_d;
      inexact_q <= inexact_d;
      tag3_q    <= tag2_q;
    end
  end
endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe at IW=32, 64 and 8 against an
// arithmetic round-to-nearest-even reference model.
module tb_itof_pipe;
  logic clk;
  logic rstn;
  int   checks;
  int   passes;

  itof_pipe_if #(.IW(32), .TW(4)) if32 ();
  itof_pipe_if #(.IW(64), .TW(4)) if64 ();
  itof_pipe_if #(.IW(8),  .TW(4)) if8  ();

  itof_pipe #(.IW(32), .TW(4)) u32 (.clk(clk), .rstn(rstn), .io(if32));
  itof_pipe #(.IW(64), .TW(4)) u64 (.clk(clk), .rstn(rstn), .io(if64));
  itof_pipe #(.IW(8),  .TW(4)) u8  (.clk(clk), .rstn(rstn), .io(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact magnitude, then round-half-even by remainder comparison.
  function automatic logic [32:0] model(input logic [63:0] xv, input int iw, input bit sgn);
    logic [64:0] mag, q, rem, half;
    logic [63:0] xm;
    bit          neg, inx;
    int          e, sh;
    xm  = 64'((65'd1 << iw) - 65'd1) & xv;
    neg = sgn && xm[iw-1];
    mag = neg ? ((65'd1 << iw) - {1'b0, xm}) : {1'b0, xm};
    if (mag == 65'd0) return 33'd0;
    e = 0;
    while ((mag >> (e + 1)) != 65'd0) e++;
    inx = 1'b0;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 65'd1 << (sh - 1);
      inx  = (rem != 65'd0);
      if (rem > half || (rem == half && q[0])) q = q + 65'd1;
      if (q == (65'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {neg, 8'(e + 127), q[22:0], inx};
  endfunction

  logic [31:0] dx [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                          32'hFFFF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'h0100_0005};
  bit          ds [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] dy [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h0000_0000,
                          32'h4F80_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002};
  bit          di [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    checks++; if (if32.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if32.out_valid); else passes++;
    checks++; if (if32.y !== 32'h0) $display("FAIL reset_y got %h exp 0", if32.y); else passes++;
    checks++; if (if32.inexact !== 1'b0) $display("FAIL reset_inexact got %b exp 0", if32.inexact); else passes++;
    checks++; if (if32.out_tag !== 4'h0) $display("FAIL reset_tag got %h exp 0", if32.out_tag); else passes++;
    checks++; if (if64.out_valid !== 1'b0 || if8.out_valid !== 1'b0)
      $display("FAIL reset_valid_wide got %b%b exp 00", if64.out_valid, if8.out_valid); else passes++;
    @(posedge clk); #1;
    rstn = 1'b1;
    if32.x = 'x;
    if32.in_tag = 'x;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (if32.in_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", if32.in_ready); else passes++;
      checks++; if (if32.out_valid !== 1'b0) $display("FAIL x_leak got %b exp 0", if32.out_valid); else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_directed();
    if32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if32.in_valid  = 1'b1;
      if32.in_signed = ds[i];
      if32.x         = dx[i];
      if32.in_tag    = 4'(i);
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      if32.x        = '0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        checks++; if (if32.out_valid !== 1'(c == 3))
          $display("FAIL latency case %0d cyc %0d got %b exp %b", i, c, if32.out_valid, c == 3); else passes++;
        if (c == 3) begin
          checks++; if (if32.y !== dy[i]) $display("FAIL dir_y case %0d got %h exp %h", i, if32.y, dy[i]); else passes++;
          checks++; if (if32.inexact !== di[i]) $display("FAIL dir_inexact case %0d got %b exp %b", i, if32.inexact, di[i]); else passes++;
          checks++; if (if32.out_tag !== 4'(i)) $display("FAIL dir_tag case %0d got %h exp %h", i, if32.out_tag, i); else passes++;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bx [6];
    logic [32:0] bexp [6];
    logic [31:0] hy;
    logic        hi;
    logic [3:0]  ht;
    int          sent, got;
    bit          stall;
    for (int i = 0; i < 6; i++) begin
      bx[i]   = $urandom;
      bexp[i] = model({32'd0, bx[i]}, 32, 1'b1);
    end
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      stall          = (cyc >= 4 && cyc <= 8);
      if32.out_ready = !stall;
      if32.in_valid  = (sent < 6);
      if32.in_signed = 1'b1;
      if32.x         = (sent < 6) ? bx[sent] : 32'd0;
      if32.in_tag    = 4'(sent);
      @(negedge clk);
      checks++; if (if32.in_ready !== !stall) $display("FAIL bp_ready cyc %0d got %b exp %b", cyc, if32.in_ready, !stall); else passes++;
      if (cyc == 4) begin
        hy = if32.y; hi = if32.inexact; ht = if32.out_tag;
      end
      if (cyc > 4 && stall) begin
        checks++; if (if32.out_valid !== 1'b1 || if32.y !== hy || if32.inexact !== hi || if32.out_tag !== ht)
          $display("FAIL bp_hold cyc %0d got %b %h %b %h exp 1 %h %b %h", cyc, if32.out_valid, if32.y,
                   if32.inexact, if32.out_tag, hy, hi, ht); else passes++;
      end
      if (if32.out_valid && if32.out_ready) begin
        checks++; if (got >= 6 || if32.out_tag !== 4'(got) || {if32.y, if32.inexact} !== bexp[got % 6])
          $display("FAIL bp_order got tag %h y %h i %b exp tag %h y %h i %b", if32.out_tag, if32.y, if32.inexact,
                   got, bexp[got % 6][32:1], bexp[got % 6][0]); else passes++;
        got++;
      end
      if (if32.in_valid && if32.in_ready) sent++;
      @(posedge clk); #1;
    end
    if32.in_valid = 1'b0;
    checks++; if (got != 6) $display("FAIL bp_count got %0d exp 6", got); else passes++;
    @(negedge clk);
    checks++; if (if32.out_valid !== 1'b0) $display("FAIL bp_dup got %b exp 0", if32.out_valid); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [36:0] exq [$];
    logic [36:0] e;
    logic [31:0] hy;
    logic        hi;
    logic [3:0]  ht;
    bit          held;
    held = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if32.in_valid  = ($urandom_range(0, 3) != 0) && cyc < 560;
      if32.in_signed = 1'($urandom_range(0, 1));
      if (($urandom_range(0, 3)) == 0) if32.x = (32'($urandom_range(1, 255)) << 24) | 32'($urandom_range(0, 15));
      else                             if32.x = $urandom >> $urandom_range(0, 31);
      if32.in_tag    = 4'($urandom);
      if32.out_ready = ($urandom_range(0, 3) != 0) || cyc >= 560;
      @(negedge clk);
      checks++; if (if32.in_ready !== (!if32.out_valid || if32.out_ready))
        $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, if32.in_ready, !if32.out_valid || if32.out_ready); else passes++;
      if (held) begin
        checks++; if (if32.out_valid !== 1'b1 || if32.y !== hy || if32.inexact !== hi || if32.out_tag !== ht)
          $display("FAIL rnd_hold cyc %0d got %h %b %h exp %h %b %h", cyc, if32.y, if32.inexact, if32.out_tag, hy, hi, ht); else passes++;
      end
      if (if32.out_valid && if32.out_ready) begin
        if (exq.size() == 0) begin
          checks++; $display("FAIL rnd_spurious cyc %0d got %h exp none", cyc, if32.y);
        end else begin
          e = exq.pop_front();
          checks++; if ({if32.y, if32.inexact, if32.out_tag} !== e)
            $display("FAIL rnd_out cyc %0d got %h %b %h exp %h %b %h", cyc, if32.y, if32.inexact, if32.out_tag,
                     e[36:5], e[4], e[3:0]); else passes++;
        end
      end
      held = if32.out_valid && !if32.out_ready;
      hy = if32.y; hi = if32.inexact; ht = if32.out_tag;
      if (if32.in_valid && if32.in_ready) exq.push_back({model({32'd0, if32.x}, 32, if32.in_signed), if32.in_tag});
      @(posedge clk); #1;
    end
    if32.in_valid = 1'b0;
    checks++; if (exq.size() != 0) $display("FAIL rnd_lost got %0d pending exp 0", exq.size()); else passes++;
  endtask

  task automatic test_widths();
    logic [36:0] q64 [$];
    logic [36:0] q8 [$];
    logic [36:0] e;
    if64.out_ready = 1'b1;
    if8.out_ready  = 1'b1;
    for (int cyc = 0; cyc < 66; cyc++) begin
      if64.in_valid = cyc < 60;
      if8.in_valid  = cyc < 60;
      if64.in_tag   = 4'(cyc);
      if8.in_tag    = 4'(cyc);
      if (cyc == 0) begin
        if64.in_signed = 1'b0; if64.x = 64'h8000_0000_0000_0000;
        if8.in_signed  = 1'b1; if8.x  = 8'h80;
      end else if (cyc == 1) begin
        if64.in_signed = 1'b0; if64.x = 64'hFFFF_FFFF_FFFF_FFFF;
        if8.in_signed  = 1'b1; if8.x  = 8'h7F;
      end else begin
        if64.in_signed = 1'($urandom_range(0, 1)); if64.x = {$urandom, $urandom} >> $urandom_range(0, 63);
        if8.in_signed  = 1'($urandom_range(0, 1)); if8.x  = 8'($urandom);
      end
      @(negedge clk);
      checks++; if (if64.out_valid !== 1'(cyc >= 3 && cyc < 63) || if8.out_valid !== 1'(cyc >= 3 && cyc < 63))
        $display("FAIL width_valid cyc %0d got %b%b exp %b", cyc, if64.out_valid, if8.out_valid, cyc >= 3 && cyc < 63); else passes++;
      if (if64.out_valid && q64.size() != 0) begin
        e = q64.pop_front();
        checks++; if ({if64.y, if64.inexact, if64.out_tag} !== e)
          $display("FAIL w64_out cyc %0d got %h %b %h exp %h %b %h", cyc, if64.y, if64.inexact, if64.out_tag,
                   e[36:5], e[4], e[3:0]); else passes++;
      end
      if (if8.out_valid && q8.size() != 0) begin
        e = q8.pop_front();
        checks++; if ({if8.y, if8.inexact, if8.out_tag} !== e)
          $display("FAIL w8_out cyc %0d got %h %b %h exp %h %b %h", cyc, if8.y, if8.inexact, if8.out_tag,
                   e[36:5], e[4], e[3:0]); else passes++;
      end
      if (if64.in_valid) begin
        if (cyc == 0)      q64.push_back({32'h5F00_0000, 1'b0, 4'(cyc)});
        else if (cyc == 1) q64.push_back({32'h5F80_0000, 1'b1, 4'(cyc)});
        else               q64.push_back({model(if64.x, 64, if64.in_signed), if64.in_tag});
        if (cyc == 0)      q8.push_back({32'hC300_0000, 1'b0, 4'(cyc)});
        else if (cyc == 1) q8.push_back({32'h42FE_0000, 1'b0, 4'(cyc)});
        else               q8.push_back({model({56'd0, if8.x}, 8, if8.in_signed), if8.in_tag});
      end
      @(posedge clk); #1;
    end
    if64.in_valid = 1'b0;
    if8.in_valid  = 1'b0;
    checks++; if (q64.size() != 0 || q8.size() != 0)
      $display("FAIL width_lost got %0d/%0d pending exp 0/0", q64.size(), q8.size()); else passes++;
  endtask

  task automatic test_reset_midstream();
    if32.out_ready = 1'b1;
    if32.in_signed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if32.in_valid = 1'b1;
      if32.x        = $urandom | 32'h1;
      if32.in_tag   = 4'(9 + i);
      @(posedge clk); #1;
    end
    if32.in_valid = 1'b0;
    checks++; if (if32.out_valid !== 1'b1) $display("FAIL mid_inflight got %b exp 1", if32.out_valid); else passes++;
    rstn = 1'b0;
    #1;
    checks++; if (if32.out_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", if32.out_valid); else passes++;
    checks++; if (if32.y !== 32'h0 || if32.inexact !== 1'b0 || if32.out_tag !== 4'h0)
      $display("FAIL mid_clear got %h %b %h exp 0 0 0", if32.y, if32.inexact, if32.out_tag); else passes++;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (if32.out_valid !== 1'b0) $display("FAIL mid_ghost cyc %0d got tag %h exp none", c, if32.out_tag); else passes++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rstn   = 1'b0;
    if32.in_valid = 1'b0; if32.in_signed = 1'b0; if32.x = '0; if32.in_tag = '0; if32.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.in_signed = 1'b0; if64.x = '0; if64.in_tag = '0; if64.out_ready = 1'b1;
    if8.in_valid  = 1'b0; if8.in_signed  = 1'b0; if8.x  = '0; if8.in_tag  = '0; if8.out_ready  = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_widths();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
